qpsk_symbol_packer: RTL and testbench

Downstream stage of the QPSK Costas/bit-sync pipeline, in the ce_clk domain, before the AXI wrapper output. Consumes the 32-bit {I,Q} AXIS stream, keeps only beats flagged by the bit-sync strobe, and hard-slices each kept beat to a 2-bit symbol. Optional differential decoding removes the Costas 90-degree phase ambiguity. Symbols are packed 16 per 32-bit word and framed into fixed-length AXIS packets.

---
 rtl/qpsk_symbol_packer.sv | 108 ++++++++++
 tb/tb_qpsk_symbol_packer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : qpsk_symbol_packer
//  Brief    : Hard-slices strobed {I,Q} beats to 2-bit QPSK symbols (Gray or
//             differential), packs 16 per word and frames fixed-length packets.
//  Revision : 1.0  initial release
// ============================================================================
module qpsk_symbol_packer #(
    parameter int PKT_WORDS     = 64,
    parameter int SYMS_PER_WORD = 16
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        clear,
    input  logic        diff_en,
    input  logic [31:0] s_tdata,
    input  logic        s_tuser,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] sym_count
);

    localparam int                  c_widx_w    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [c_widx_w-1:0] c_last_word = c_widx_w'(PKT_WORDS - 1);
    localparam logic [3:0]          c_last_sym  = 4'(SYMS_PER_WORD - 1);

    logic                r_ready_en;
    logic [29:0]         r_acc;
    logic [3:0]          r_sym_idx;
    logic [c_widx_w-1:0] r_word_idx;
    logic [1:0]          r_prev_phase;

    logic                w_accept;
    logic                w_sym_en;
    logic                w_out_hs;
    logic                w_word_done;
    logic [1:0]          w_phase;
    logic [1:0]          w_symbol;
    logic [31:0]         w_word;
    logic [c_widx_w-1:0] w_widx_inc;
    logic [c_widx_w-1:0] w_widx_cur;

    // Clear takes priority over any beat presented in the same cycle.
    assign s_tready = r_ready_en & ~clear & (~m_tvalid | m_tready);

    assign w_accept    = s_tvalid & s_tready;
    assign w_sym_en    = w_accept & s_tuser;
    assign w_out_hs    = m_tvalid & m_tready;
    assign w_word_done = w_sym_en & (r_sym_idx == c_last_sym);

    // Quadrant phase: (+,+)=0, (-,+)=1, (-,-)=2, (+,-)=3 from the sign bits.
    assign w_phase  = {s_tdata[15], s_tdata[31] ^ s_tdata[15]};
    assign w_symbol = diff_en ? (w_phase - r_prev_phase) : {s_tdata[31], s_tdata[15]};
    assign w_word   = {r_acc, w_symbol};

    assign w_widx_inc = (r_word_idx == c_last_word) ? '0 : r_word_idx + 1'b1;
    // Index of the word that would occupy the output register after this edge.
    assign w_widx_cur = w_out_hs ? w_widx_inc : r_word_idx;

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            r_ready_en   <= 1'b0;
            r_acc        <= '0;
            r_sym_idx    <= '0;
            r_word_idx   <= '0;
            r_prev_phase <= '0;
            m_tdata      <= '0;
            m_tlast      <= 1'b0;
            m_tvalid     <= 1'b0;
            sym_count    <= '0;
        end else if (clear) begin
            r_ready_en   <= 1'b1;
            r_acc        <= '0;
            r_sym_idx    <= '0;
            r_word_idx   <= '0;
            r_prev_phase <= '0;
            m_tdata      <= '0;
            m_tlast      <= 1'b0;
            m_tvalid     <= 1'b0;
            sym_count    <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_out_hs) begin
                r_word_idx <= w_widx_inc;
            end
            if (w_sym_en) begin
                r_acc        <= w_word[29:0];
                r_sym_idx    <= r_sym_idx + 4'd1;
                r_prev_phase <= w_phase;
                sym_count    <= sym_count + 32'd1;
            end
            if (w_word_done) begin
                m_tdata  <= w_word;
                m_tlast  <= (w_widx_cur == c_last_word);
                m_tvalid <= 1'b1;
            end else if (w_out_hs) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qpsk_symbol_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_qpsk_symbol_packer
//  Brief    : Table vectors, corner sequences and random traffic against a
//             queue-based symbol/word reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qpsk_symbol_packer;

    localparam int PKT_WORDS = 4;

    logic        ce_clk = 1'b0;
    logic        ce_rst = 1'b1;
    logic        clear = 1'b0;
    logic        diff_en = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tuser = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] sym_count;

    qpsk_symbol_packer #(.PKT_WORDS(PKT_WORDS), .SYMS_PER_WORD(16)) dut (
        .ce_clk(ce_clk), .ce_rst(ce_rst), .clear(clear), .diff_en(diff_en),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .sym_count(sym_count)
    );

    always #5 ce_clk = ~ce_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: completed words wait in a queue until handshaken.
    logic [32:0] m_q[$];
    int unsigned m_cnt;
    int          m_nsym;
    logic [31:0] m_acc;
    int          m_prev;
    int          m_words;
    int          hs_num;
    int          last_pos[$];

    function automatic void model_reset();
        m_q.delete();
        m_cnt   = 0;
        m_nsym  = 0;
        m_acc   = '0;
        m_prev  = 0;
        m_words = 0;
    endfunction

    function automatic int quadrant(input logic [31:0] d);
        logic signed [15:0] iv;
        logic signed [15:0] qv;
        iv = d[31:16];
        qv = d[15:0];
        if (iv >= 0 && qv >= 0) return 0;
        if (iv < 0 && qv >= 0) return 1;
        if (iv < 0 && qv < 0) return 2;
        return 3;
    endfunction

    task automatic step(input logic v, input logic u, input logic [31:0] d,
                        input logic rdy, input logic dif);
        logic exp_rdy;
        int   p;
        int   s;
        @(negedge ce_clk);
        s_tvalid = v;
        s_tuser  = u;
        s_tdata  = d;
        m_tready = rdy;
        diff_en  = dif;
        #1;
        exp_rdy = (m_q.size() == 0) || rdy;
        check("s_tready", s_tready, exp_rdy);
        check("m_tvalid", m_tvalid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("m_tdata", m_tdata, m_q[0][31:0]);
            check("m_tlast", m_tlast, m_q[0][32]);
        end
        check("sym_count", sym_count, m_cnt);
        if (m_q.size() != 0 && rdy) begin
            if (m_q[0][32]) last_pos.push_back(hs_num);
            hs_num++;
            void'(m_q.pop_front());
        end
        if (v && exp_rdy && u) begin
            p = quadrant(d);
            if (dif) s = (p - m_prev + 4) % 4;
            else     s = (d[31] ? 2 : 0) + (d[15] ? 1 : 0);
            m_prev = p;
            m_acc  = m_acc * 4 + 32'(s);
            m_cnt++;
            m_nsym++;
            if (m_nsym == 16) begin
                m_q.push_back({(m_words % PKT_WORDS) == PKT_WORDS - 1, m_acc});
                m_words++;
                m_nsym = 0;
            end
        end
    endtask

    task automatic do_clear();
        @(negedge ce_clk);
        s_tvalid = 1'b0;
        clear    = 1'b1;
        @(negedge ce_clk);
        clear = 1'b0;
        #1;
        model_reset();
        check("clear_m_tvalid", m_tvalid, 1'b0);
        check("clear_sym_count", sym_count, 32'd0);
    endtask

    typedef struct {
        logic [3:0][31:0] beats;
        logic             diff;
        logic [31:0]      exp_word;
    } vec_t;

    localparam logic [31:0] PP = 32'h0064_0064;
    localparam logic [31:0] MP = 32'hFF9C_0064;
    localparam logic [31:0] MM = 32'hFF9C_FF9C;
    localparam logic [31:0] PM = 32'h0064_FF9C;

    vec_t tbl[8];

    initial begin
        tbl[0].beats = {MM, PP, MM, PP};                     tbl[0].diff = 0; tbl[0].exp_word = 32'h3333_3333;
        tbl[1].beats = {4{32'hFFFF_0005}};                   tbl[1].diff = 0; tbl[1].exp_word = 32'hAAAA_AAAA;
        tbl[2].beats = {4{32'h0000_0000}};                   tbl[2].diff = 0; tbl[2].exp_word = 32'h0000_0000;
        tbl[3].beats = {4{32'h0000_FFFF}};                   tbl[3].diff = 0; tbl[3].exp_word = 32'h5555_5555;
        tbl[4].beats = {PM, MM, MP, PP};                     tbl[4].diff = 1; tbl[4].exp_word = 32'h1555_5555;
        tbl[5].beats = {4{MM}};                              tbl[5].diff = 1; tbl[5].exp_word = 32'h8000_0000;
        tbl[6].beats = {MP, PP, MP, PP};                     tbl[6].diff = 1; tbl[6].exp_word = 32'h1DDD_DDDD;
        tbl[7].beats = {PP, MM, PM, MP};                     tbl[7].diff = 0; tbl[7].exp_word = 32'h9C9C_9C9C;

        model_reset();
        hs_num = 0;
        repeat (3) @(negedge ce_clk);
        #1;
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_m_tlast", m_tlast, 1'b0);
        check("rst_sym_count", sym_count, 32'd0);
        ce_rst = 1'b0;

        // Table vectors, each from a cleared state so prev_phase starts at 0.
        for (int e = 0; e < 8; e++) begin
            do_clear();
            for (int k = 0; k < 16; k++) step(1'b1, 1'b1, tbl[e].beats[k % 4], 1'b1, tbl[e].diff);
            step(1'b0, 1'b0, 32'd0, 1'b1, tbl[e].diff);
            check("table_valid", m_tvalid, 1'b1);
            check("table_word", m_tdata, tbl[e].exp_word);
        end

        // Strobe gating: only every fourth beat carries a symbol.
        do_clear();
        for (int k = 0; k < 64; k++) step(1'b1, (k % 4) == 3, 32'hFFFF_0005, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("gate_sym_count", sym_count, 32'd16);
        check("gate_word", m_tdata, 32'hAAAA_AAAA);

        // Framing: two packets of four words, tlast on words 4 and 8.
        do_clear();
        last_pos.delete();
        hs_num = 0;
        for (int k = 0; k < 128; k++) step(1'b1, 1'b1, PP, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("frame_words", hs_num, 32'd8);
        check("frame_nlast", last_pos.size(), 32'd2);
        if (last_pos.size() == 2) begin
            check("frame_last0", last_pos[0], 32'd3);
            check("frame_last1", last_pos[1], 32'd7);
        end

        // Backpressure: word pending with m_tready low for 20 cycles.
        do_clear();
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
        check("bp_sym_count", sym_count, 32'd16);
        check("bp_s_tready", s_tready, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b1, 1'b1, $urandom, 1'b1, 1'($urandom % 2));

        // Clear mid-packet: two words plus seven symbols are discarded.
        do_clear();
        for (int k = 0; k < 39; k++) step(1'b1, 1'b1, PP, 1'b1, 1'b0);
        do_clear();
        last_pos.delete();
        hs_num = 0;
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, MP, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("clr_word", m_tdata, 32'hAAAA_AAAA);
        check("clr_last", m_tlast, 1'b0);
        check("clr_sym_count", sym_count, 32'd16);
        for (int k = 0; k < 48; k++) step(1'b1, 1'b1, MP, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("clr_nlast", last_pos.size(), 32'd1);
        if (last_pos.size() == 1) check("clr_last_pos", last_pos[0], 32'd3);

        // Random traffic with occasional clears.
        for (int k = 0; k < 4000; k++) begin
            if (($urandom % 600) == 0) do_clear();
            step(1'(($urandom % 4) != 0), 1'(($urandom % 3) != 0), $urandom,
                 1'(($urandom % 4) != 0), 1'($urandom % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
